ifmap_window_scheduler: RTL and testbench

Sequencer that drives the Ifmap BRAM address counter. It walks a programmed set of BRAM banks and, within each bank, a programmed number of equal-length address windows (tiles). For each window it presents `if_addr_start`, `if_addr_end` and `ifmap_sel_in`, pulses `start` into the counter, and waits for the counter's `if_done` before moving on. It sits between the transposed-convolution top-level control FSM and the Ifmap counter.

---
 rtl/ifmap_window_scheduler.sv | 174 +++++++++++++++++
 tb/tb_ifmap_window_scheduler.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifmap_window_scheduler.sv
// Window sequencer for the Ifmap BRAM address counter: walks banks (outer) and
// equal-length tiles (inner), issuing one counter start per window.
module ifmap_window_scheduler #(
    parameter int NUM_BRAMS  = 16,
    parameter int ADDR_WIDTH = 9,
    parameter int TILE_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_start,
    input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
    input  logic [ADDR_WIDTH-1:0] cfg_tile_len,
    input  logic [ADDR_WIDTH-1:0] cfg_tile_stride,
    input  logic [TILE_W-1:0]     cfg_num_tiles,
    input  logic [3:0]            cfg_sel_first,
    input  logic [3:0]            cfg_sel_last,
    input  logic                  ds_ready,
    input  logic                  ctr_done,
    output logic                  ctr_start,
    output logic [ADDR_WIDTH-1:0] if_addr_start,
    output logic [ADDR_WIDTH-1:0] if_addr_end,
    output logic [3:0]            ifmap_sel_in,
    output logic [TILE_W-1:0]     tile_idx,
    output logic                  busy,
    output logic                  sched_done,
    output logic                  cfg_err
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        NEXT,
        FINISH
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] base_q, len_q, stride_q;
    logic [TILE_W-1:0]     num_tiles_q;
    logic [3:0]            sel_last_q;

    logic [ADDR_WIDTH-1:0] cur_q, cur_d, len_eff;
    logic [3:0]            bank_q, bank_d;
    logic [TILE_W-1:0]     tile_q, tile_d;
    logic                  err_q, err_d;

    logic [ADDR_WIDTH-1:0] addr_start_q, addr_end_q;
    logic [3:0]            sel_q;

    logic [ADDR_WIDTH:0]   cur_end, next_end;
    logic                  cfg_bad, accept, load_out;

    always_comb begin
        cfg_bad = (cfg_tile_len == '0) || (cfg_num_tiles == '0) ||
                  (cfg_sel_first > cfg_sel_last) ||
                  (int'(cfg_sel_last) >= NUM_BRAMS);
        cur_end = {1'b0, cur_q} + {1'b0, len_q} - 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        bank_d    = bank_q;
        tile_d    = tile_q;
        err_d     = 1'b0;
        ctr_start = 1'b0;
        accept    = 1'b0;
        len_eff   = len_q;
        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    if (cfg_bad) begin
                        err_d = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        state_d = ISSUE;
                        cur_d   = cfg_base_addr;
                        bank_d  = cfg_sel_first;
                        tile_d  = '0;
                        len_eff = cfg_tile_len;
                    end
                end
            end
            ISSUE: begin
                if (ds_ready) begin
                    if (cur_end[ADDR_WIDTH]) begin
                        err_d   = 1'b1;
                        state_d = FINISH;
                    end else begin
                        ctr_start = 1'b1;
                        state_d   = WAIT;
                    end
                end
            end
            WAIT: begin
                if (ctr_done) state_d = NEXT;
            end
            NEXT: begin
                if (({1'b0, tile_q} + 1'b1) < {1'b0, num_tiles_q}) begin
                    tile_d  = tile_q + 1'b1;
                    cur_d   = cur_q + stride_q;
                    state_d = ISSUE;
                end else if (bank_q < sel_last_q) begin
                    bank_d  = bank_q + 1'b1;
                    tile_d  = '0;
                    cur_d   = base_q;
                    state_d = ISSUE;
                end else begin
                    state_d = FINISH;
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Window registers are loaded on entry to ISSUE so they are already
        // valid in the cycle ctr_start fires; an overflowing window never loads.
        next_end = {1'b0, cur_d} + {1'b0, len_eff} - 1'b1;
        load_out = (state_q != ISSUE) && (state_d == ISSUE) && !next_end[ADDR_WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cur_q   <= '0;
            bank_q  <= '0;
            tile_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            bank_q  <= bank_d;
            tile_q  <= tile_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q      <= '0;
            len_q       <= '0;
            stride_q    <= '0;
            num_tiles_q <= '0;
            sel_last_q  <= '0;
        end else if (accept) begin
            base_q      <= cfg_base_addr;
            len_q       <= cfg_tile_len;
            stride_q    <= cfg_tile_stride;
            num_tiles_q <= cfg_num_tiles;
            sel_last_q  <= cfg_sel_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_start_q <= '0;
            addr_end_q   <= '0;
            sel_q        <= '0;
        end else if (load_out) begin
            addr_start_q <= cur_d;
            addr_end_q   <= next_end[ADDR_WIDTH-1:0];
            sel_q        <= bank_d;
        end
    end

    assign if_addr_start = addr_start_q;
    assign if_addr_end   = addr_end_q;
    assign ifmap_sel_in  = sel_q;
    assign tile_idx      = tile_q;
    assign busy          = (state_q != IDLE);
    assign sched_done    = (state_q == FINISH);
    assign cfg_err       = err_q;

endmodule

// File: tb/tb_ifmap_window_scheduler.sv
// Scoreboard bench for ifmap_window_scheduler: a closed-form window list is
// queued per request and a negedge monitor checks every start/done/error.
module tb_ifmap_window_scheduler;

    typedef struct {
        int kind;   // 0 window, 1 done, 2 overflow done, 3 config error
        int s;
        int e;
        int sel;
        int tile;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_start;
    logic [8:0] cfg_base_addr, cfg_tile_len, cfg_tile_stride;
    logic [7:0] cfg_num_tiles;
    logic [3:0] cfg_sel_first, cfg_sel_last;
    logic       ds_ready;
    logic       model_done, spur_done;
    wire        ctr_done = model_done | spur_done;
    logic       ctr_start;
    logic [8:0] if_addr_start, if_addr_end;
    logic [3:0] ifmap_sel_in;
    logic [7:0] tile_idx;
    logic       busy, sched_done, cfg_err;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   rand_ready = 1'b1;
    logic ready_val = 1'b1;
    int   done_delay = 0;
    exp_t sb[$];

    ifmap_window_scheduler #(.NUM_BRAMS(16), .ADDR_WIDTH(9), .TILE_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start),
        .cfg_base_addr(cfg_base_addr), .cfg_tile_len(cfg_tile_len),
        .cfg_tile_stride(cfg_tile_stride), .cfg_num_tiles(cfg_num_tiles),
        .cfg_sel_first(cfg_sel_first), .cfg_sel_last(cfg_sel_last),
        .ds_ready(ds_ready), .ctr_done(ctr_done), .ctr_start(ctr_start),
        .if_addr_start(if_addr_start), .if_addr_end(if_addr_end),
        .ifmap_sel_in(ifmap_sel_in), .tile_idx(tile_idx), .busy(busy),
        .sched_done(sched_done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        ds_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ds_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_val;
        end
    end

    // Counter model: answers each start with a done pulse after a delay.
    initial begin
        int n;
        model_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && ctr_start) begin
                n = (done_delay > 0) ? done_delay : int'($urandom_range(1, 6));
                repeat (n) @(posedge clk);
                #1;
                if (rst_n) begin
                    model_done = 1'b1;
                    @(posedge clk);
                    #1;
                    model_done = 1'b0;
                end
            end
        end
    end

    // Monitor
    initial begin
        exp_t e;
        bit   in_wait;
        int   last_done, idle_at;
        logic [8:0] cap_s, cap_e;
        logic [3:0] cap_sel;
        logic [7:0] cap_tile;
        in_wait = 0; last_done = -100; idle_at = -1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb.delete();
                in_wait = 0;
                idle_at = -1;
            end else begin
                if (in_wait) begin
                    checks++;
                    if (if_addr_start != cap_s || if_addr_end != cap_e ||
                        ifmap_sel_in != cap_sel || tile_idx != cap_tile) begin
                        errors++;
                        $display("FAIL wait_stable: got %0d..%0d sel %0d tile %0d, want %0d..%0d sel %0d tile %0d",
                                 if_addr_start, if_addr_end, ifmap_sel_in, tile_idx, cap_s, cap_e, cap_sel, cap_tile);
                    end
                end
                if (ctr_done) begin
                    last_done = cyc;
                    in_wait = 0;
                end
                if (idle_at == cyc) begin
                    checks++;
                    if (busy !== 1'b0) begin
                        errors++;
                        $display("FAIL busy_after_done: got %b want 0", busy);
                    end
                    idle_at = -1;
                end
                if (ctr_start) begin
                    checks++;
                    if (ds_ready !== 1'b1) begin
                        errors++;
                        $display("FAIL start_without_ready: ds_ready %b want 1", ds_ready);
                    end
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_start: got window %0d..%0d sel %0d, want none", if_addr_start, if_addr_end, ifmap_sel_in);
                    end else begin
                        e = sb.pop_front();
                        if (e.kind != 0 || if_addr_start != e.s || if_addr_end != e.e ||
                            ifmap_sel_in != e.sel || tile_idx != e.tile) begin
                            errors++;
                            $display("FAIL window: got %0d..%0d sel %0d tile %0d, want kind %0d %0d..%0d sel %0d tile %0d",
                                     if_addr_start, if_addr_end, ifmap_sel_in, tile_idx, e.kind, e.s, e.e, e.sel, e.tile);
                        end
                    end
                    cap_s = if_addr_start; cap_e = if_addr_end;
                    cap_sel = ifmap_sel_in; cap_tile = tile_idx;
                    in_wait = 1;
                end
                if (sched_done) begin
                    checks++;
                    idle_at = cyc + 1;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_done: got sched_done, want none");
                    end else begin
                        e = sb.pop_front();
                        if ((e.kind != 1 && e.kind != 2) || cfg_err !== (e.kind == 2)) begin
                            errors++;
                            $display("FAIL sched_done: got done with cfg_err %b, want kind %0d", cfg_err, e.kind);
                        end else if (e.kind == 1 && cyc != last_done + 2) begin
                            errors++;
                            $display("FAIL done_latency: got %0d cycles after ctr_done, want 2", cyc - last_done);
                        end
                    end
                end else if (cfg_err) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_cfg_err: got 1 want 0");
                    end else begin
                        e = sb.pop_front();
                        if (e.kind != 3) begin
                            errors++;
                            $display("FAIL cfg_err: got config error, want kind %0d", e.kind);
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    function automatic bit is_bad(input int l, input int n, input int f, input int la);
        return (l == 0) || (n == 0) || (f > la) || (la >= 16);
    endfunction

    // Reference: windows in bank-outer/tile-inner order, tile t starts at
    // base + t*stride (mod 512); first window that runs past 511 aborts.
    task automatic build_exp(input int b, input int l, input int s, input int n,
                             input int f, input int la);
        exp_t e;
        int st, en;
        if (is_bad(l, n, f, la)) begin
            e = '{3, 0, 0, 0, 0};
            sb.push_back(e);
            return;
        end
        for (int bk = f; bk <= la; bk++) begin
            for (int t = 0; t < n; t++) begin
                st = (b + t * s) % 512;
                en = st + l - 1;
                if (en >= 512) begin
                    e = '{2, 0, 0, 0, 0};
                    sb.push_back(e);
                    return;
                end
                e = '{0, st, en, bk, t};
                sb.push_back(e);
            end
        end
        e = '{1, 0, 0, 0, 0};
        sb.push_back(e);
    endtask

    // Returns at cycle 1 (one cycle after the request edge).
    task automatic start_cfg(input int b, input int l, input int s, input int n,
                             input int f, input int la);
        tick();
        cfg_base_addr = 9'(b); cfg_tile_len = 9'(l); cfg_tile_stride = 9'(s);
        cfg_num_tiles = 8'(n); cfg_sel_first = 4'(f); cfg_sel_last = 4'(la);
        build_exp(b, l, s, n, f, la);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        cfg_base_addr = 9'($urandom); cfg_tile_len = 9'($urandom);
        cfg_tile_stride = 9'($urandom); cfg_num_tiles = 8'($urandom);
        cfg_sel_first = 4'($urandom); cfg_sel_last = 4'($urandom);
    endtask

    task automatic wait_idle(input int bound);
        int k = 0;
        while (busy && k < bound) begin
            tick();
            k++;
        end
        check("idle_timeout", int'(busy), 0);
        tick();
        check("scoreboard_drained", sb.size(), 0);
    endtask

    task automatic wait_start(input int bound);
        int k = 0;
        while (!ctr_start && k < bound) begin
            tick();
            k++;
        end
        check("start_timeout", int'(ctr_start), 1);
    endtask

    task automatic check_err_pulse();
        check("err_cycle1", int'(cfg_err), 1);
        check("err_busy", int'(busy), 0);
        check("err_no_start", int'(ctr_start), 0);
        tick();
        check("err_pulse_end", int'(cfg_err), 0);
        check("err_busy_after", int'(busy), 0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctr_start"}, int'(ctr_start), 0);
        check({name, "_busy"}, int'(busy), 0);
        check({name, "_sched_done"}, int'(sched_done), 0);
        check({name, "_cfg_err"}, int'(cfg_err), 0);
        check({name, "_addr_start"}, int'(if_addr_start), 0);
        check({name, "_addr_end"}, int'(if_addr_end), 0);
        check({name, "_sel"}, int'(ifmap_sel_in), 0);
        check({name, "_tile"}, int'(tile_idx), 0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, l, s, n, f, la;
        rst_n = 1'b0; cfg_start = 1'b0; spur_done = 1'b0;
        cfg_base_addr = '0; cfg_tile_len = '0; cfg_tile_stride = '0;
        cfg_num_tiles = '0; cfg_sel_first = '0; cfg_sel_last = '0;
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Single window with fixed counter latency and earliest start
        rand_ready = 1'b0; ready_val = 1'b1; done_delay = 6;
        repeat (2) tick();
        start_cfg(10, 4, 0, 1, 3, 3);
        check("single_busy", int'(busy), 1);
        check("single_start_cycle1", int'(ctr_start), 1);
        check("single_addr_start", int'(if_addr_start), 10);
        check("single_addr_end", int'(if_addr_end), 13);
        check("single_sel", int'(ifmap_sel_in), 3);
        wait_idle(100);
        check("hold_addr_idle", int'(if_addr_end), 13);

        // Bank x tile sweep, with a request pulsed during WAIT
        rand_ready = 1'b1; done_delay = 0;
        start_cfg(0, 8, 8, 3, 2, 3);
        wait_start(100);
        tick();
        cfg_base_addr = 9'd100; cfg_tile_len = 9'd3; cfg_num_tiles = 8'd1;
        cfg_sel_first = 4'd0; cfg_sel_last = 4'd0;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        wait_idle(500);

        // Backpressure
        rand_ready = 1'b0; ready_val = 1'b0;
        repeat (2) tick();
        start_cfg(40, 5, 0, 1, 1, 1);
        for (int i = 0; i < 5; i++) begin
            check("bp_no_start", int'(ctr_start), 0);
            check("bp_busy", int'(busy), 1);
            if (i == 4) ready_val = 1'b1;
            tick();
        end
        check("bp_ready_high", int'(ds_ready), 1);
        check("bp_start_on_rise", int'(ctr_start), 1);
        rand_ready = 1'b1;
        wait_idle(200);

        // Config errors
        start_cfg(0, 0, 1, 1, 0, 0);
        check_err_pulse();
        start_cfg(0, 4, 1, 0, 0, 0);
        check_err_pulse();
        start_cfg(0, 4, 1, 1, 5, 4);
        check_err_pulse();

        // Overflow: last legal window, then aborts
        start_cfg(500, 8, 4, 2, 0, 0);
        wait_idle(200);
        start_cfg(505, 8, 4, 2, 6, 6);
        wait_idle(200);
        start_cfg(500, 8, 4, 3, 7, 8);
        wait_idle(200);

        // Stray ctr_done while idle has no effect
        spur_done = 1'b1;
        tick();
        spur_done = 1'b0;
        check("spur_busy", int'(busy), 0);
        check("spur_no_start", int'(ctr_start), 0);

        // Reset during WAIT, then a normal run
        done_delay = 5;
        start_cfg(0, 8, 8, 3, 2, 3);
        wait_start(100);
        tick();
        check("rst_in_wait_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (8) tick();
        done_delay = 0;
        start_cfg(20, 6, 10, 2, 0, 1);
        wait_idle(300);

        // Randomized configurations
        for (int i = 0; i < 30; i++) begin
            b = $urandom_range(0, 511); l = $urandom_range(1, 40);
            s = $urandom_range(0, 150); n = $urandom_range(1, 4);
            f = $urandom_range(0, 15);  la = f + $urandom_range(0, 2);
            if (la > 15) la = 15;
            if (i % 8 == 7) begin
                case ($urandom_range(0, 2))
                    0: l = 0;
                    1: n = 0;
                    default: begin f = 9; la = 3; end
                endcase
            end
            start_cfg(b, l, s, n, f, la);
            if (is_bad(l, n, f, la)) check_err_pulse();
            else wait_idle(3000);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
